// File: rtl/ofdm_pkg.sv
// Shared OFDM link constants: bin plan, pilot amplitude, frame header byte.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ofdm_pkg;

    // Pilot bins; data occupies the gaps between PILOT1..PILOT4.
    localparam int PILOT0 = 21;
    localparam int PILOT1 = 22;
    localparam int PILOT2 = 55;
    localparam int PILOT3 = 88;
    localparam int PILOT4 = 121;

    localparam int INDEX_BEGIN = 21;
    localparam int INDEX_END   = 121;
    localparam int DATA_BITS   = 96;

    // Offset subtracted from the bin number in each data segment so that
    // the three 32-bin segments yield contiguous data indices 0..95.
    localparam int DATA_OFS0 = PILOT1 + 1;  // bins 23..54  -> idx 0..31
    localparam int DATA_OFS1 = PILOT1 + 2;  // bins 56..87  -> idx 32..63
    localparam int DATA_OFS2 = PILOT1 + 3;  // bins 89..120 -> idx 64..95

    localparam logic [15:0] PILOT_AMPLITUDE = 16'h4000;
    localparam logic [7:0]  HEADER_BYTE     = 8'h55;

    typedef enum logic {
        IDLE,
        WRITE
    } tx_state_t;

    // Data index to payload bit position: bytes are sent MSB first, so the
    // bit within each byte is reversed while the byte order is kept.
    function automatic logic [6:0] data_bit_sel(input logic [6:0] idx);
        return idx ^ 7'd7;
    endfunction

endpackage

// File: rtl/ofdm_tx_bin_map.sv
// Maps one folded bin index to the real part of its spectral value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module ofdm_tx_bin_map
    import ofdm_pkg::*;
#(
    parameter int          KW        = 11,
    parameter logic [15:0] AMPLITUDE = PILOT_AMPLITUDE
) (
    input  logic [KW-1:0]        k,
    input  logic [DATA_BITS-1:0] payload_q,
    output logic [15:0]          re
);

    localparam logic [15:0] NEG_AMPLITUDE = ~AMPLITUDE + 16'd1;

    int         kk;
    logic       is_pilot;
    logic       is_data;
    logic [6:0] idx;

    // Classify the bin and derive the data index for BPSK bins.
    always_comb begin
        kk       = int'(k);
        is_pilot = (kk == PILOT0) || (kk == PILOT1) || (kk == PILOT2) ||
                   (kk == PILOT3) || (kk == PILOT4);
        is_data  = 1'b0;
        idx      = '0;
        re       = '0;
        if (kk >= INDEX_BEGIN && kk <= INDEX_END && !is_pilot) begin
            is_data = 1'b1;
            if (kk < PILOT2) begin
                idx = 7'(kk - DATA_OFS0);
            end else if (kk < PILOT3) begin
                idx = 7'(kk - DATA_OFS1);
            end else begin
                idx = 7'(kk - DATA_OFS2);
            end
        end
        if (is_pilot) begin
            re = AMPLITUDE;
        end else if (is_data) begin
            re = payload_q[data_bit_sel(idx)] ? AMPLITUDE : NEG_AMPLITUDE;
        end
    end

endmodule

// File: rtl/ofdm_tx_mapper.sv
// Writes one Hermitian-symmetric FFT_LEN-bin spectrum (pilots + BPSK data) per frame to BSRAM.
// Latency: address n written at edge n+1 after start; finish at edge FFT_LEN.
// Backpressure: none; start is ignored while busy, BSRAM accepts one write per cycle.
module ofdm_tx_mapper
    import ofdm_pkg::*;
#(
    parameter int          FFT_LEN   = 2048,
    parameter logic [15:0] AMPLITUDE = PILOT_AMPLITUDE,
    localparam int         AW        = $clog2(FFT_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] payload,
    output logic                 busy,
    output logic                 finish,
    input  logic                 clear,
    output logic                 frame_ok,
    output logic                 ce,
    output logic                 wre,
    output logic [AW-1:0]        ad,
    output logic [31:0]          din
);

    localparam logic [AW-1:0] LAST = AW'(FFT_LEN - 1);
    localparam logic [AW-1:0] HALF = AW'(FFT_LEN / 2);

    tx_state_t            state;
    logic [DATA_BITS-1:0] payload_q;
    logic [AW-1:0]        next_ad;
    logic [AW-1:0]        bin_k;
    logic [15:0]          bin_re;
    logic                 finish_set;

    // Next address to present and its bin after folding the upper half
    // onto the lower one (N - a), which gives the conjugate-symmetric copy.
    always_comb begin
        next_ad    = (state == IDLE) ? '0 : ad + 1'b1;
        bin_k      = (next_ad > HALF) ? ('0 - next_ad) : next_ad;
        finish_set = (state == WRITE) && (ad == LAST);
    end

    ofdm_tx_bin_map #(
        .KW        (AW),
        .AMPLITUDE (AMPLITUDE)
    ) u_bin_map (
        .k         (bin_k),
        .payload_q (payload_q),
        .re        (bin_re)
    );

    // Frame FSM: accept start, stream FFT_LEN writes, then raise finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            payload_q <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            frame_ok  <= 1'b0;
            ce        <= 1'b0;
            wre       <= 1'b0;
            ad        <= '0;
            din       <= '0;
        end else begin
            // Setting finish takes priority over a coincident clear.
            if (clear && !finish_set) begin
                finish   <= 1'b0;
                frame_ok <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        payload_q <= payload;
                        frame_ok  <= (payload[7:0] == HEADER_BYTE) &&
                                     (payload[DATA_BITS-1 -: 8] == HEADER_BYTE);
                        ad        <= '0;
                        din       <= {bin_re, 16'h0000};
                        ce        <= 1'b1;
                        wre       <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (ad == LAST) begin
                        ce     <= 1'b0;
                        wre    <= 1'b0;
                        busy   <= 1'b0;
                        finish <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        ad  <= next_ad;
                        din <= {bin_re, 16'h0000};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_tx_mapper.sv
// Scoreboard bench for ofdm_tx_mapper: expected BSRAM writes queued at start, popped by a write monitor.
// Latency: checks finish at edge 2048 after start and the clear/finish priority.
// Backpressure: none; also covers ignored restart, async reset and a DSP loopback.
module tb_ofdm_tx_mapper;

    localparam int N = 2048;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [95:0] payload = '0;
    logic        busy, finish, frame_ok, ce, wre;
    logic [10:0] ad;
    logic [31:0] din;

    ofdm_tx_mapper #(.FFT_LEN(N), .AMPLITUDE(16'h4000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .payload(payload),
        .busy(busy), .finish(finish), .clear(clear), .frame_ok(frame_ok),
        .ce(ce), .wre(wre), .ad(ad), .din(din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] ad;
        logic [31:0] din;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         exp_q[$];
    logic [31:0] mem [0:N-1];
    int          bin_idx [0:N/2];
    real         xr [0:N-1];
    real         xi [0:N-1];

    task automatic check_vec(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit is_pilot(input int k);
        return k == 21 || k == 22 || k == 55 || k == 88 || k == 121;
    endfunction

    // Expected word for BSRAM address a given the frame payload.
    function automatic logic [31:0] exp_word(input int a, input logic [95:0] p);
        int k, id;
        k  = (a <= N/2) ? a : N - a;
        id = bin_idx[k];
        if (id == -1) return 32'h0;
        if (id == -2) return 32'h40000000;
        return p[(id / 8) * 8 + 7 - (id % 8)] ? 32'h40000000 : 32'hC0000000;
    endfunction

    // BSRAM model.
    always @(posedge clk) begin
        if (ce && wre) mem[ad] <= din;
    end

    // Write monitor: every write the DUT presents must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (ce && wre) begin
            if (exp_q.size() == 0) begin
                check_vec("unexpected_write", 96'(ad), 96'h7FF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_vec("write_ad", 96'(ad), 96'(e.ad));
                check_vec("write_din", 96'(din), 96'(e.din));
            end
        end
    end

    task automatic push_frame(input logic [95:0] p);
        for (int a = 0; a < N; a++) exp_q.push_back({11'(a), exp_word(a, p)});
    endtask

    // Called #1 after an edge; start is sampled on the next edge.
    task automatic start_frame(input logic [95:0] p);
        push_frame(p);
        payload = p;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_finish();
        int n = 0;
        while (!finish && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        check_vec("finish_timeout", 96'(finish), 96'(1));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    task automatic count_data(input logic [31:0] want, output int bad);
        bad = 0;
        for (int k = 1; k <= N/2; k++) begin
            if (bin_idx[k] >= 0) begin
                if (mem[k] !== want) bad++;
                if (mem[N-k] !== want) bad++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_busy"}, 96'(busy), 96'(0));
        check_vec({tag, "_finish"}, 96'(finish), 96'(0));
        check_vec({tag, "_frame_ok"}, 96'(frame_ok), 96'(0));
        check_vec({tag, "_ce"}, 96'(ce), 96'(0));
        check_vec({tag, "_wre"}, 96'(wre), 96'(0));
        check_vec({tag, "_ad"}, 96'(ad), 96'(0));
        check_vec({tag, "_din"}, 96'(din), 96'(0));
    endtask

    // Iterative radix-2 FFT on xr/xi; inv selects the scaled inverse.
    task automatic fft(input bit inv);
        int  j, bitv, half;
        real ang, wr, wi, ur, ui, vr, vi, tr;
        j = 0;
        for (int i = 1; i < N; i++) begin
            bitv = N / 2;
            while ((j & bitv) != 0) begin
                j    = j ^ bitv;
                bitv = bitv >> 1;
            end
            j = j ^ bitv;
            if (i < j) begin
                tr = xr[i]; xr[i] = xr[j]; xr[j] = tr;
                tr = xi[i]; xi[i] = xi[j]; xi[j] = tr;
            end
        end
        for (int len = 2; len <= N; len = len * 2) begin
            half = len / 2;
            ang  = (inv ? 2.0 : -2.0) * PI / len;
            for (int s = 0; s < N; s += len) begin
                for (int m = 0; m < half; m++) begin
                    wr = $cos(ang * m);
                    wi = $sin(ang * m);
                    ur = xr[s+m];
                    ui = xi[s+m];
                    vr = xr[s+m+half] * wr - xi[s+m+half] * wi;
                    vi = xr[s+m+half] * wi + xi[s+m+half] * wr;
                    xr[s+m]      = ur + vr;
                    xi[s+m]      = ui + vi;
                    xr[s+m+half] = ur - vr;
                    xi[s+m+half] = ui - vi;
                end
            end
        end
        if (inv) begin
            for (int i = 0; i < N; i++) begin
                xr[i] = xr[i] / N;
                xi[i] = xi[i] / N;
            end
        end
    endtask

    // Spectrum in mem -> IFFT -> FFT -> receive demapper.
    task automatic loopback(input logic [95:0] p);
        logic signed [15:0] s16;
        logic [95:0]        res;
        real                max_im;
        bit                 pilots_ok, success;
        int                 idx;
        for (int a = 0; a < N; a++) begin
            s16   = mem[a][31:16];
            xr[a] = real'(s16);
            s16   = mem[a][15:0];
            xi[a] = real'(s16);
        end
        fft(1'b1);
        max_im = 0.0;
        for (int a = 0; a < N; a++) begin
            if (xi[a] > max_im) max_im = xi[a];
            if (-xi[a] > max_im) max_im = -xi[a];
        end
        check_vec("ifft_output_real", 96'(max_im < 1.0e-3), 96'(1));
        fft(1'b0);
        res       = '0;
        idx       = 0;
        pilots_ok = 1'b1;
        for (int k = 21; k <= 121; k++) begin
            if (is_pilot(k)) begin
                if (!(xr[k] > 0.0)) pilots_ok = 1'b0;
            end else begin
                res[(idx / 8) * 8 + 7 - (idx % 8)] = (xr[k] > 0.0);
                idx++;
            end
        end
        success = pilots_ok && res[7:0] == 8'h55 && res[95:88] == 8'h55;
        check_vec("loopback_res", res, p);
        check_vec("loopback_success", 96'(success), 96'(1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] pa, p;
        int          bad, pulses, data_id;

        // Bench's own bin plan: -1 zero, -2 pilot, else sequential data index.
        data_id = 0;
        for (int k = 0; k <= N/2; k++) begin
            bin_idx[k] = -1;
            if (k >= 21 && k <= 121) begin
                if (is_pilot(k)) bin_idx[k] = -2;
                else begin
                    bin_idx[k] = data_id;
                    data_id++;
                end
            end
        end

        // Reset values.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame A with header/trailer, exact cycle checks.
        pa = {8'h55, 80'h0, 8'h55};
        push_frame(pa);
        payload = pa;
        start   = 1'b1;
        @(posedge clk);                          // E0
        #1 start = 1'b0;
        check_vec("e0_busy", 96'(busy), 96'(1));
        check_vec("e0_ce_wre", 96'({ce, wre}), 96'(2'b11));
        check_vec("e0_ad", 96'(ad), 96'(0));
        repeat (4) @(posedge clk);               // E4
        #1 payload = '1;
        start = 1'b1;
        @(posedge clk);                          // E5: ignored restart
        #1 start = 1'b0;
        payload = '0;
        repeat (2042) @(posedge clk);            // E2047
        #1 check_vec("e2047_finish", 96'(finish), 96'(0));
        check_vec("e2047_busy", 96'(busy), 96'(1));
        check_vec("frame_ok_header", 96'(frame_ok), 96'(1));
        clear = 1'b1;
        @(posedge clk);                          // E2048
        #1 clear = 1'b0;
        check_vec("e2048_finish_over_clear", 96'(finish), 96'(1));
        check_vec("e2048_frame_ok_kept", 96'(frame_ok), 96'(1));
        check_vec("e2048_busy_ce_wre", 96'({busy, ce, wre}), 96'(0));
        @(posedge clk);                          // E2049
        #1 clear = 1'b1;
        @(posedge clk);                          // E2050
        #1 clear = 1'b0;
        check_vec("e2050_finish_cleared", 96'(finish), 96'(0));
        check_vec("e2050_frame_ok_cleared", 96'(frame_ok), 96'(0));
        check_int("frame_a_queue_drained", exp_q.size(), 0);
        check_vec("bin23", 96'(mem[23]), 96'(32'hC0000000));
        check_vec("bin30", 96'(mem[30]), 96'(32'h40000000));
        check_vec("pilot21", 96'(mem[21]), 96'(32'h40000000));
        check_vec("pilot22", 96'(mem[22]), 96'(32'h40000000));
        check_vec("pilot55", 96'(mem[55]), 96'(32'h40000000));
        check_vec("pilot88", 96'(mem[88]), 96'(32'h40000000));
        check_vec("pilot121", 96'(mem[121]), 96'(32'h40000000));
        check_vec("bin0", 96'(mem[0]), 96'(0));
        check_vec("bin1024", 96'(mem[1024]), 96'(0));
        bad = 0;
        for (int k = 1; k < N/2; k++) if (mem[N-k] !== mem[k]) bad++;
        check_int("mirror_mismatches", bad, 0);

        // All-ones payload: no header, every data bin positive.
        start_frame('1);
        wait_finish();
        check_vec("ones_frame_ok", 96'(frame_ok), 96'(0));
        count_data(32'h40000000, bad);
        check_int("ones_data_bins", bad, 0);
        do_clear();

        // All-zeros payload: every data bin negative; finish left set.
        start_frame('0);
        wait_finish();
        count_data(32'hC0000000, bad);
        check_int("zeros_data_bins", bad, 0);

        // Reset in the middle of a frame.
        p = {8'h55, 80'h0123_4567_89AB_CDEF_F00D, 8'h55};
        push_frame(p);
        payload = p;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (ce || wre) pulses++;
        end
        check_int("no_write_after_reset", pulses, 0);
        check_vec("idle_after_reset", 96'(busy), 96'(0));

        // Loopback through IFFT/FFT and the receive demapper.
        for (int f = 0; f < 20; f++) begin
            p = {8'h55, 32'($urandom), 32'($urandom), 16'($urandom), 8'h55};
            start_frame(p);
            wait_finish();
            check_vec("loopback_frame_ok", 96'(frame_ok), 96'(1));
            do_clear();
            loopback(p);
        end

        check_int("final_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
